intr_ctrl: RTL and testbench

Machine-mode interrupt controller that sequences timer and external interrupts into the pipelined core. It owns the machine timer (mtime/mtimecmp), synchronises the external IRQ line, and arbitrates between the two sources. When an interrupt is taken it stalls fetch, drains the pipeline, pulses the CSR file's t_intr/e_intr inputs and flushes. It then masks further interrupts until mret.

---
 rtl/intr_pkg.sv | 17 +
 rtl/sync_2ff.sv | 17 +
 rtl/intr_ctrl.sv | 125 ++++++++++++
 tb/tb_intr_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/intr_pkg.sv
// intr_pkg: shared types and constants for the machine-mode interrupt controller
package intr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        TAKE    = 2'd2,
        HANDLER = 2'd3
    } intr_state_e;

    localparam logic [31:0] MCAUSE_MTI = 32'h8000_0007;
    localparam logic [31:0] MCAUSE_MEI = 32'h8000_000B;

    localparam int MIP_MTIP = 0;
    localparam int MIP_MEIP = 1;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous level input
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // shift the asynchronous level through two flops to settle metastability
    always_ff @(posedge clk or posedge rst) begin
        if (rst) {q, meta} <= 2'b00;
        else     {q, meta} <= {meta, d};
    end

endmodule

// File: rtl/intr_ctrl.sv
// intr_ctrl: machine timer, external IRQ sync and trap sequencing (timer gated by INTR_CTRL_TIMER_EN)
module intr_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int TMR_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ext_irq,
    input  logic             mstatus_mie,
    input  logic             mie_mtie,
    input  logic             mie_meie,
    input  logic             tcmp_wr,
    input  logic [TMR_W-1:0] tcmp_wdata,
    input  logic             tmr_clr,
    input  logic             mem_busy,
    input  logic             is_mret,
    output logic             stall_f,
    output logic             flush,
    output logic             t_intr,
    output logic             e_intr,
    output logic [31:0]      mcause,
    output logic [1:0]       mip,
    output logic             in_handler,
    output logic [TMR_W-1:0] mtime
);

    import intr_pkg::*;

    localparam int CW = $clog2(DRAIN_CYCLES + 1);
`ifdef INTR_CTRL_TIMER_EN
    localparam bit TMR_EN = 1'b1;
`else
    localparam bit TMR_EN = 1'b0;
`endif

    intr_state_e   state, state_nx;
    logic [CW-1:0] cnt;
    logic          meip, mtip, ext_req, tmr_req, req, sel_ext;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (ext_irq),
        .q   (meip)
    );

`ifdef INTR_CTRL_TIMER_EN
    logic [TMR_W-1:0] mtimecmp;

    // free-running timer; a clear beats the increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mtime <= '0;
        else     mtime <= tmr_clr ? '0 : mtime + TMR_W'(1);
    end

    // compare register resets to all-ones so the timer starts quiet
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          mtimecmp <= '1;
        else if (tcmp_wr) mtimecmp <= tcmp_wdata;
    end

    // registered timer-pending level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mtip <= 1'b0;
        else     mtip <= (mtime >= mtimecmp);
    end
`else
    logic unused_tmr;
    assign unused_tmr = ^{tcmp_wr, tcmp_wdata, tmr_clr};
    assign mtime      = '0;
    assign mtip       = 1'b0;
`endif

    assign ext_req        = meip & mie_meie;
    assign tmr_req        = mtip & mie_mtie;
    assign req            = mstatus_mie & (ext_req | tmr_req);
    assign mip[MIP_MEIP]  = meip;
    assign mip[MIP_MTIP]  = mtip;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next state: drain until counter expires and memory is idle, then trap or abort
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = req ? DRAIN : IDLE;
            DRAIN:   state_nx = (cnt == '0 && !mem_busy) ? (req ? TAKE : IDLE) : DRAIN;
            TAKE:    state_nx = HANDLER;
            HANDLER: state_nx = is_mret ? IDLE : HANDLER;
            default: state_nx = IDLE;
        endcase
    end

    // drain counter: loaded on entry, counts down to zero and then waits on mem_busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          cnt <= '0;
        else if (state == IDLE && req)    cnt <= CW'(DRAIN_CYCLES - 1);
        else if (state == DRAIN && cnt != '0) cnt <= cnt - CW'(1);
    end

    // latch the arbitration winner as the trap is committed; external beats timer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_ext <= 1'b0;
            mcause  <= '0;
        end else if (state == DRAIN && state_nx == TAKE) begin
            sel_ext <= ext_req;
            mcause  <= ext_req ? MCAUSE_MEI : MCAUSE_MTI;
        end
    end

    // outputs decoded from state so reset drops them immediately
    always_comb begin
        stall_f    = (state == DRAIN) || (state == TAKE);
        flush      = (state == TAKE);
        e_intr     = (state == TAKE) && sel_ext;
        t_intr     = TMR_EN && (state == TAKE) && !sel_ext;
        in_handler = (state == HANDLER);
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: self-checking bench for intr_ctrl (timer checks follow INTR_CTRL_TIMER_EN)
`timescale 1ns/1ps
module tb_intr_ctrl;

    import intr_pkg::*;

    localparam int TW = 8;

    logic          clk = 1'b0, rst = 1'b1, ext_irq = 1'b0, mstatus_mie = 1'b0;
    logic          mie_mtie = 1'b0, mie_meie = 1'b0, tcmp_wr = 1'b0, tmr_clr = 1'b0;
    logic          mem_busy = 1'b0, is_mret = 1'b0;
    logic [TW-1:0] tcmp_wdata = '0;
    logic          stall_f, flush, t_intr, e_intr, in_handler;
    logic [31:0]   mcause;
    logic [1:0]    mip;
    logic [TW-1:0] mtime;

    int total = 0, bad = 0, cyc = 0;

    typedef struct { logic ext; logic [31:0] cause; int at; } exp_t;
    typedef struct { logic mie; logic meie; int busy; logic trap; } vec_t;

    exp_t exp_q[$];
    exp_t e;
    vec_t vecs[5];

    intr_ctrl #(.DRAIN_CYCLES(2), .TMR_W(TW)) dut (
        .clk         (clk),
        .rst         (rst),
        .ext_irq     (ext_irq),
        .mstatus_mie (mstatus_mie),
        .mie_mtie    (mie_mtie),
        .mie_meie    (mie_meie),
        .tcmp_wr     (tcmp_wr),
        .tcmp_wdata  (tcmp_wdata),
        .tmr_clr     (tmr_clr),
        .mem_busy    (mem_busy),
        .is_mret     (is_mret),
        .stall_f     (stall_f),
        .flush       (flush),
        .t_intr      (t_intr),
        .e_intr      (e_intr),
        .mcause      (mcause),
        .mip         (mip),
        .in_handler  (in_handler),
        .mtime       (mtime)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, expv);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mret();
        is_mret = 1'b1;
        tick();
        is_mret = 1'b0;
    endtask

    // scoreboard: every trap pulse must match the oldest expected record
    always @(negedge clk) begin
        if (!rst && (t_intr || e_intr)) begin
            if (exp_q.size() == 0) chk("unexpected pulse", {30'd0, t_intr, e_intr}, 32'd0);
            else begin
                e = exp_q.pop_front();
                chk("pulse src", {30'd0, t_intr, e_intr}, e.ext ? 32'd1 : 32'd2);
                chk("pulse cause", mcause, e.cause);
                chk("pulse cycle", cyc, e.at);
                chk("pulse flush/stall", {30'd0, flush, stall_f}, 32'd3);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, m;
        vecs[0] = '{1'b1, 1'b1, 0, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 5, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 2, 1'b1};

        // reset mid-count
        tick(2);
        rst = 1'b0;
        tick(10);
        #2 rst = 1'b1;
        #1;
        chk("rst mtime", 32'(mtime), 32'd0);
        chk("rst outs", {27'd0, stall_f, flush, t_intr, e_intr, in_handler}, 32'd0);
        chk("rst mcause", mcause, 32'd0);
        tick();
        rst = 1'b0;
        tick(2);
        chk("rst mip", 32'(mip), 32'd0);

        // abort: source drops while memory holds the drain
        mstatus_mie = 1'b1; mie_meie = 1'b1; mie_mtie = 1'b0; mem_busy = 1'b1; ext_irq = 1'b1;
        tick(5);
        chk("abort stall", 32'(stall_f), 32'd1);
        ext_irq = 1'b0;
        tick(5);
        mem_busy = 1'b0;
        tick();
        chk("abort released", {29'd0, stall_f, flush, in_handler}, 32'd0);

        // mret outside the handler is ignored
        is_mret = 1'b1;
        tick(3);
        chk("idle mret", {30'd0, stall_f, in_handler}, 32'd0);
        is_mret = 1'b0;
        tick(2);

        // external-source vectors
        for (int i = 0; i < 5; i++) begin
            mstatus_mie = vecs[i].mie;
            mie_meie    = vecs[i].meie;
            mem_busy    = vecs[i].busy > 0;
            ext_irq     = 1'b1;
            p = cyc;
            if (vecs[i].trap) exp_q.push_back('{1'b1, MCAUSE_MEI, p + 5 + vecs[i].busy});
            for (int k = 0; k < 12 + vecs[i].busy; k++) begin
                tick();
                if (vecs[i].trap && vecs[i].busy > 0 && cyc == p + 4 + vecs[i].busy)
                    chk("busy stall", 32'(stall_f), 32'd1);
                if (cyc == p + 4 + vecs[i].busy) mem_busy = 1'b0;
            end
            chk("vec handler", 32'(in_handler), 32'(vecs[i].trap));
            chk("vec stall", 32'(stall_f), 32'd0);
            ext_irq = 1'b0;
            tick(4);
            if (vecs[i].trap) begin
                chk("vec held", 32'(in_handler), 32'd1);
                mret();
                chk("vec mret", 32'(in_handler), 32'd0);
            end
            tick(2);
        end

        // reset in the middle of a drain
        mstatus_mie = 1'b1; mie_meie = 1'b1; mem_busy = 1'b1; ext_irq = 1'b1;
        tick(4);
        chk("drain stall", 32'(stall_f), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("drain rst outs", {27'd0, stall_f, flush, t_intr, e_intr, in_handler}, 32'd0);
        chk("drain rst mip", 32'(mip), 32'd0);
        ext_irq = 1'b0; mem_busy = 1'b0; mie_meie = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(3);
        chk("post rst stall", 32'(stall_f), 32'd0);

`ifdef INTR_CTRL_TIMER_EN
        // timer trap at mtimecmp=20
        mie_mtie = 1'b1; tmr_clr = 1'b1; tcmp_wr = 1'b1; tcmp_wdata = 8'd20;
        p = cyc;
        exp_q.push_back('{1'b0, MCAUSE_MTI, p + 25});
        tick();
        tmr_clr = 1'b0; tcmp_wr = 1'b0;
        chk("tmr clr", 32'(mtime), 32'd0);
        tick(20);
        chk("tmr at cmp", 32'(mtime), 32'd20);
        chk("mtip before", 32'(mip[MIP_MTIP]), 32'd0);
        tick();
        chk("mtip after", 32'(mip[MIP_MTIP]), 32'd1);
        tick(6);
        chk("tmr handler", 32'(in_handler), 32'd1);

        // both sources pending: external first, then timer
        mie_meie = 1'b1; ext_irq = 1'b1;
        tick(4);
        chk("hdl ignores req", {30'd0, stall_f, in_handler}, 32'd1);
        m = cyc + 1;
        exp_q.push_back('{1'b1, MCAUSE_MEI, m + 3});
        mret();
        chk("mret idle", {30'd0, stall_f, in_handler}, 32'd0);
        tick();
        chk("redrain", 32'(stall_f), 32'd1);
        tick(4);
        ext_irq = 1'b0;
        tick(4);
        m = cyc + 1;
        exp_q.push_back('{1'b0, MCAUSE_MTI, m + 3});
        mret();
        tick(6);
        chk("second handler", 32'(in_handler), 32'd1);
        mie_mtie = 1'b0;
        mret();
        tick(2);
        chk("final idle", {30'd0, stall_f, in_handler}, 32'd0);

        // wrap from all-ones to zero
        tmr_clr = 1'b1;
        tick();
        tmr_clr = 1'b0;
        tick(255);
        chk("tmr max", 32'(mtime), 32'd255);
        tick();
        chk("tmr wrap", 32'(mtime), 32'd0);
`else
        // without the timer, its controls do nothing
        mie_mtie = 1'b1; tmr_clr = 1'b1; tcmp_wr = 1'b1; tcmp_wdata = 8'd0;
        tick();
        tmr_clr = 1'b0; tcmp_wr = 1'b0;
        tick(6);
        chk("no tmr mtime", 32'(mtime), 32'd0);
        chk("no tmr mip", 32'(mip), 32'd0);
        chk("no tmr trap", {30'd0, stall_f, in_handler}, 32'd0);
        mie_mtie = 1'b0;
`endif

        tick(5);
        chk("missing pulses", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
